// File: rtl/lif_neuron_ctrl.sv
// Leaky integrate-and-fire neuron controller driving an external unclocked magnitude comparator.
// Optional `define LIF_SPIKE_COUNT_EN adds count_clr input and saturating spike_count output.
module lif_neuron_ctrl #(
  parameter int WIDTH         = 8,
  parameter int REFRAC_CYCLES = 4,
  parameter int LEAK_SHIFT    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_weight,
  input  logic             in_inhib,
  input  logic             leak_tick,
  input  logic [WIDTH-1:0] thresh_cfg,
  output logic [WIDTH-1:0] cmp_a,
  output logic [WIDTH-1:0] cmp_b,
  input  logic             cmp_lt,
  input  logic             cmp_eq,
  input  logic             cmp_gt,
  output logic             spike,
  output logic             refractory,
  output logic             cmp_err
`ifdef LIF_SPIKE_COUNT_EN
  ,
  input  logic             count_clr,
  output logic [15:0]      spike_count
`endif
);

  typedef enum logic [2:0] {ACCUM, SETTLE, DECIDE, FIRE, REFRAC} state_t;

  localparam int CW = (REFRAC_CYCLES < 2) ? 1 : $clog2(REFRAC_CYCLES + 1);
  localparam logic [CW-1:0] REFRAC_LOAD = CW'(REFRAC_CYCLES);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] pot, pot_nxt;
  logic [WIDTH-1:0] thr_q, thr_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             err_q, err_nxt;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] leaked;
  logic             one_hot;

  assign sum     = {1'b0, pot} + {1'b0, in_weight};
  assign diff    = pot - in_weight;
  assign leaked  = pot - (pot >> LEAK_SHIFT);
  // Odd parity rules out 0 and 2 bits set; the AND term rules out all three.
  assign one_hot = (cmp_lt ^ cmp_eq ^ cmp_gt) & ~(cmp_lt & cmp_eq & cmp_gt);

  assign in_ready   = (state == ACCUM);
  assign spike      = (state == FIRE);
  assign refractory = (state == REFRAC);
  assign cmp_a      = pot;
  assign cmp_b      = thr_q;
  assign cmp_err    = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
      pot   <= '0;
      thr_q <= '1;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      pot   <= pot_nxt;
      thr_q <= thr_nxt;
      cnt   <= cnt_nxt;
      err_q <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pot_nxt   = pot;
    thr_nxt   = thr_q;
    cnt_nxt   = cnt;
    err_nxt   = err_q;
    case (state)
      ACCUM: begin
        thr_nxt = thresh_cfg;
        if (in_valid && in_ready) begin
          if (in_inhib) pot_nxt = (in_weight > pot) ? '0 : diff;
          else          pot_nxt = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
          state_nxt = SETTLE;
        end else if (leak_tick) begin
          pot_nxt = leaked;
        end
      end
      SETTLE: state_nxt = DECIDE;
      DECIDE: begin
        if (!one_hot) begin
          err_nxt   = 1'b1;
          state_nxt = ACCUM;
        end else if (cmp_lt) begin
          state_nxt = ACCUM;
        end else begin
          state_nxt = FIRE;
        end
      end
      FIRE: begin
        pot_nxt = '0;
        if (REFRAC_CYCLES == 0) begin
          state_nxt = ACCUM;
        end else begin
          cnt_nxt   = REFRAC_LOAD;
          state_nxt = REFRAC;
        end
      end
      REFRAC: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt_nxt == '0) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

`ifdef LIF_SPIKE_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      spike_count <= '0;
    else if (count_clr)                              spike_count <= '0;
    else if ((state == FIRE) && (spike_count != '1)) spike_count <= spike_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_lif_neuron_ctrl.sv
// Self-checking bench for lif_neuron_ctrl; comparator modelled combinationally from cmp_a/cmp_b.
module tb_lif_neuron_ctrl;
  localparam int W  = 8;
  localparam int RC = 4;
  localparam int LS = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_weight = '0;
  logic         in_inhib = 1'b0;
  logic         leak_tick = 1'b0;
  logic [W-1:0] thresh_cfg = '0;
  logic [W-1:0] cmp_a, cmp_b;
  logic         cmp_lt, cmp_eq, cmp_gt;
  logic         spike, refractory, cmp_err;
  logic         force_bad = 1'b0;
`ifdef LIF_SPIKE_COUNT_EN
  logic         count_clr = 1'b0;
  logic [15:0]  spike_count;
  int           m_count = 0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int m_pot    = 0;
  bit m_err    = 1'b0;

  always #5 clk = ~clk;

  always_comb begin
    if (force_bad) begin
      cmp_lt = 1'b1; cmp_eq = 1'b0; cmp_gt = 1'b1;
    end else begin
      cmp_lt = (cmp_a < cmp_b);
      cmp_eq = (cmp_a == cmp_b);
      cmp_gt = (cmp_a > cmp_b);
    end
  end

  lif_neuron_ctrl #(.WIDTH(W), .REFRAC_CYCLES(RC), .LEAK_SHIFT(LS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_weight(in_weight), .in_inhib(in_inhib), .leak_tick(leak_tick),
    .thresh_cfg(thresh_cfg), .cmp_a(cmp_a), .cmp_b(cmp_b),
    .cmp_lt(cmp_lt), .cmp_eq(cmp_eq), .cmp_gt(cmp_gt),
    .spike(spike), .refractory(refractory), .cmp_err(cmp_err)
`ifdef LIF_SPIKE_COUNT_EN
    , .count_clr(count_clr), .spike_count(spike_count)
`endif
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    while (in_ready !== 1'b1 && k < 30) begin
      step();
      k++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_ready[%s]: in_ready=%b required 1 within 30 cycles", tag, in_ready);
    end
  endtask

  // One event through ACCUM->SETTLE->DECIDE->(FIRE->REFRAC*)->ACCUM, checked against the model.
  task automatic do_event(input int w, input bit inh, input int thr, input bit with_leak,
                          input bit bad, input bit clr_on_fire, input string tag);
    int exp_pot;
    bit fire;
    wait_ready(tag);
    thresh_cfg = 8'(thr);
    in_valid   = 1'b1;
    in_weight  = 8'(w);
    in_inhib   = inh;
    leak_tick  = with_leak;
    exp_pot = inh ? m_pot - w : m_pot + w;
    if (exp_pot > 255) exp_pot = 255;
    if (exp_pot < 0)   exp_pot = 0;
    m_pot = exp_pot;
    fire  = !bad && (exp_pot >= thr);
    step();
    in_valid   = 1'b0;
    leak_tick  = 1'b0;
    in_weight  = 8'($urandom);
    in_inhib   = 1'($urandom);
    thresh_cfg = 8'($urandom);
    if (bad) force_bad = 1'b1;
    n_checks++;
    if (cmp_a !== 8'(exp_pot) || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL settle[%s]: cmp_a=%0d in_ready=%b required cmp_a=%0d in_ready=0", tag, cmp_a, in_ready, exp_pot);
    end
    step();
    n_checks++;
    if (cmp_b !== 8'(thr) || spike !== 1'b0 || in_ready !== 1'b0 || cmp_a !== 8'(exp_pot)) begin
      n_fail++;
      $display("FAIL decide[%s]: cmp_b=%0d spike=%b in_ready=%b cmp_a=%0d required cmp_b=%0d spike=0 in_ready=0 cmp_a=%0d",
               tag, cmp_b, spike, in_ready, cmp_a, thr, exp_pot);
    end
    step();
    force_bad = 1'b0;
    if (bad) m_err = 1'b1;
    n_checks++;
    if (spike !== fire || cmp_err !== m_err) begin
      n_fail++;
      $display("FAIL outcome[%s]: spike=%b cmp_err=%b required spike=%b cmp_err=%b", tag, spike, cmp_err, fire, m_err);
    end
    if (fire) begin
`ifdef LIF_SPIKE_COUNT_EN
      count_clr = clr_on_fire;
`endif
      step();
`ifdef LIF_SPIKE_COUNT_EN
      count_clr = 1'b0;
      if (clr_on_fire) m_count = 0;
      else if (m_count < 65535) m_count++;
`endif
      m_pot = 0;
      for (int i = 0; i < RC; i++) begin
        n_checks++;
        if (refractory !== 1'b1 || in_ready !== 1'b0 || spike !== 1'b0 || cmp_a !== 8'd0) begin
          n_fail++;
          $display("FAIL refrac[%s] cycle %0d: refractory=%b in_ready=%b spike=%b cmp_a=%0d required 1 0 0 0",
                   tag, i, refractory, in_ready, spike, cmp_a);
        end
        step();
      end
    end
    n_checks++;
    if (in_ready !== 1'b1 || refractory !== 1'b0 || spike !== 1'b0 || cmp_a !== 8'(m_pot)) begin
      n_fail++;
      $display("FAIL back_to_accum[%s]: in_ready=%b refractory=%b spike=%b cmp_a=%0d required 1 0 0 %0d",
               tag, in_ready, refractory, spike, cmp_a, m_pot);
    end
`ifdef LIF_SPIKE_COUNT_EN
    n_checks++;
    if (spike_count !== 16'(m_count)) begin
      n_fail++;
      $display("FAIL spike_count[%s]: spike_count=%0d required %0d", tag, spike_count, m_count);
    end
`endif
  endtask

  task automatic do_leak(input string tag);
    wait_ready(tag);
    leak_tick = 1'b1;
    step();
    leak_tick = 1'b0;
    m_pot = m_pot - m_pot / (1 << LS);
    n_checks++;
    if (cmp_a !== 8'(m_pot) || in_ready !== 1'b1 || spike !== 1'b0) begin
      n_fail++;
      $display("FAIL leak[%s]: cmp_a=%0d in_ready=%b spike=%b required cmp_a=%0d in_ready=1 spike=0",
               tag, cmp_a, in_ready, spike, m_pot);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    n_checks++;
    if ({in_ready, spike, refractory, cmp_err} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_flags: ready/spike/refr/err=%b required 1000", {in_ready, spike, refractory, cmp_err});
    end
    n_checks++;
    if (cmp_a !== 8'd0 || cmp_b !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_cmp: cmp_a=%0h cmp_b=%0h required 00 ff", cmp_a, cmp_b);
    end
    rst_n = 1'b1;
    step();
    m_pot = 0;
    m_err = 1'b0;
  endtask

  task automatic test_basic();
    do_event(60, 1'b0, 100, 1'b0, 1'b0, 1'b0, "basic_60");
    do_event(50, 1'b0, 100, 1'b0, 1'b0, 1'b0, "basic_110");
  endtask

  task automatic test_saturate();
    do_event(250, 1'b0, 255, 1'b0, 1'b0, 1'b0, "sat_250");
    do_event(20,  1'b0, 255, 1'b0, 1'b0, 1'b0, "sat_255_eq");
    do_event(5,   1'b0, 255, 1'b0, 1'b0, 1'b0, "inh_pre5");
    do_event(10,  1'b1, 255, 1'b0, 1'b0, 1'b0, "inh_floor");
  endtask

  task automatic test_leak();
    do_event(80, 1'b0, 255, 1'b0, 1'b0, 1'b0, "leak_pre80");
    do_leak("leak_80_70");
    do_event(10, 1'b0, 255, 1'b0, 1'b0, 1'b0, "leak_to80");
    do_event(5,  1'b0, 255, 1'b1, 1'b0, 1'b0, "leak_dropped");
  endtask

  task automatic test_cmp_err();
    do_event(0, 1'b0, 10,  1'b0, 1'b1, 1'b0, "cmp_err_set");
    do_event(1, 1'b0, 255, 1'b0, 1'b0, 1'b0, "cmp_err_sticky");
  endtask

  task automatic test_hold_refrac();
    wait_ready("hold");
    thresh_cfg = 8'd20;
    in_valid   = 1'b1;
    in_weight  = 8'd30;
    in_inhib   = 1'b0;
    step();
    in_weight = 8'd7;
    step();
    step();
    n_checks++;
    if (spike !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_fire: spike=%b required 1", spike);
    end
    step();
`ifdef LIF_SPIKE_COUNT_EN
    if (m_count < 65535) m_count++;
`endif
    for (int i = 0; i < RC; i++) begin
      n_checks++;
      if (in_ready !== 1'b0 || refractory !== 1'b1 || cmp_a !== 8'd0) begin
        n_fail++;
        $display("FAIL hold_refrac cycle %0d: in_ready=%b refractory=%b cmp_a=%0d required 0 1 0", i, in_ready, refractory, cmp_a);
      end
      step();
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_first_accum: in_ready=%b required 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    n_checks++;
    if (cmp_a !== 8'd7 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_accepted: cmp_a=%0d in_ready=%b required cmp_a=7 in_ready=0", cmp_a, in_ready);
    end
    step();
    step();
    m_pot = 7;
    n_checks++;
    if (in_ready !== 1'b1 || spike !== 1'b0 || cmp_a !== 8'd7) begin
      n_fail++;
      $display("FAIL hold_done: in_ready=%b spike=%b cmp_a=%0d required 1 0 7", in_ready, spike, cmp_a);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        do_leak("rand_leak");
      end else begin
        do_event(int'($urandom_range(0, 90)), ($urandom_range(0, 2) == 0),
                 int'($urandom_range(20, 255)), 1'($urandom), 1'b0, 1'b0, "rand_event");
      end
    end
  endtask

  task automatic test_reset_refrac();
    wait_ready("rst_refrac");
    thresh_cfg = 8'd10;
    in_valid   = 1'b1;
    in_weight  = 8'd50;
    in_inhib   = 1'b0;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    n_checks++;
    if (refractory !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_refrac_pre: refractory=%b required 1", refractory);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, spike, refractory, cmp_err} !== 4'b1000 || cmp_a !== 8'd0 || cmp_b !== 8'hFF) begin
      n_fail++;
      $display("FAIL rst_refrac_async: ready/spike/refr/err=%b cmp_a=%0h cmp_b=%0h required 1000 00 ff",
               {in_ready, spike, refractory, cmp_err}, cmp_a, cmp_b);
    end
`ifdef LIF_SPIKE_COUNT_EN
    n_checks++;
    if (spike_count !== 16'd0) begin
      n_fail++;
      $display("FAIL rst_refrac_count: spike_count=%0d required 0", spike_count);
    end
    m_count = 0;
`endif
    step();
    rst_n = 1'b1;
    step();
    m_pot = 0;
    m_err = 1'b0;
  endtask

`ifdef LIF_SPIKE_COUNT_EN
  task automatic test_spike_count();
    for (int i = 0; i < 3; i++) do_event(10, 1'b0, 1, 1'b0, 1'b0, 1'b0, "count_fire");
    n_checks++;
    if (spike_count !== 16'd3) begin
      n_fail++;
      $display("FAIL count_three: spike_count=%0d required 3", spike_count);
    end
    do_event(10, 1'b0, 1, 1'b0, 1'b0, 1'b1, "count_clr_wins");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_leak();
    test_cmp_err();
    test_hold_refrac();
    test_random();
    test_reset_refrac();
`ifdef LIF_SPIKE_COUNT_EN
    test_spike_count();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/lif_neuron_ctrl.md
Name: lif_neuron_ctrl

Overview:
Sequential leaky integrate-and-fire neuron controller, and the driving end of the unclocked 8-bit magnitude comparator interface.
- Integrates weighted input events into a membrane potential and applies a periodic leak.
- Drives potential and threshold onto the comparator A/B inputs, then samples the LT/EQ/GT result after a settle cycle.
- Emits a one-cycle spike and enters a refractory period.
- Sits between the synapse/event fabric and the threshold comparator.

Parameters:
WIDTH, 8, potential/threshold/weight width (must match the comparator width).
REFRAC_CYCLES, 4, refractory length in cycles; 0 = no refractory.
LEAK_SHIFT, 3, leak amount = potential >> LEAK_SHIFT per leak_tick.

Ports:
clk  in  1  single clock.
rst_n  in  1  asynchronous, active-low reset.
in_valid  in  1  input event valid.
in_ready  out  1  controller can accept an event.
in_weight  in  WIDTH  unsigned event magnitude.
in_inhib  in  1  1 = subtract weight, 0 = add weight.
leak_tick  in  1  apply one leak step.
thresh_cfg  in  WIDTH  firing threshold.
cmp_a  out  WIDTH  membrane potential to comparator A.
cmp_b  out  WIDTH  registered threshold to comparator B.
cmp_lt  in  1  comparator A<B.
cmp_eq  in  1  comparator A==B.
cmp_gt  in  1  comparator A>B.
spike  out  1  one-cycle fire pulse.
refractory  out  1  high while in REFRAC.
cmp_err  out  1  sticky, comparator result not one-hot.

Behaviour:
- Reset (async on rst_n low, released synchronously to clk):
  - state=ACCUM; potential (cmp_a)=0; cmp_b=all ones; spike=0; refractory=0; cmp_err=0; refractory counter=0.
  - Asserting reset mid-operation in any state returns to these values immediately.
- States: ACCUM, SETTLE, DECIDE, FIRE, REFRAC.
- ACCUM:
  - in_ready=1; cmp_b <= thresh_cfg every cycle.
  - On in_valid & in_ready:
    - potential <= potential + in_weight, saturating at 2^WIDTH-1, or potential - in_weight, saturating at 0, selected by in_inhib.
    - Next state SETTLE.
  - Else on leak_tick: potential <= potential - (potential >> LEAK_SHIFT); stay in ACCUM (no compare).
  - in_valid and leak_tick in the same cycle: the event wins and that leak_tick is dropped.
- SETTLE:
  - in_ready=0; cmp_a and cmp_b held stable so the unclocked comparator resolves; one cycle, then DECIDE.
- DECIDE:
  - in_ready=0; sample cmp_lt/eq/gt.
  - Exactly one high:
    - gt or eq -> FIRE.
    - lt -> ACCUM.
  - Not one-hot: set cmp_err (sticky until reset) and go to ACCUM without firing.
- FIRE:
  - spike=1 for exactly this cycle; potential <= 0.
  - Next state REFRAC with counter=REFRAC_CYCLES, or ACCUM if REFRAC_CYCLES==0.
- REFRAC:
  - refractory=1, in_ready=0; leak_tick ignored; counter decrements each cycle.
  - Exactly REFRAC_CYCLES cycles, then ACCUM.
- Latency: an event accepted at the edge ending cycle n gives SETTLE in n+1, DECIDE in n+2, spike in n+3.
- Handshake: valid/ready, with transfer on the cycle both are high. in_weight and in_inhib are sampled only on transfer. The upstream block holds in_valid and its data while in_ready=0.
- cmp_b changes only in ACCUM, so the threshold is stable through SETTLE/DECIDE even if thresh_cfg changes.

Optional Feature:
LIF_SPIKE_COUNT_EN
- Defined:
  - Adds output spike_count [15:0], reset 0, incremented in FIRE, saturating at 16'hFFFF.
  - Adds input count_clr, a synchronous clear; on simultaneous FIRE and count_clr, the clear wins and the count is 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Bench models the comparator combinationally from cmp_a/cmp_b.
- thresh_cfg=100; events +60, then +50 -> no spike after first (potential 60); spike exactly 3 cycles after the second accept; potential 0; refractory high 4 cycles; in_ready low for SETTLE..REFRAC.
- Potential 250, event +20 -> potential 255 (saturated). Potential 5, inhibitory event 10 -> potential 0. No spike with thresh_cfg=255 after the first, spike after the second (eq path).
- Potential 80, LEAK_SHIFT=3, leak_tick pulse -> potential 70. leak_tick and in_valid(+5) in the same cycle -> potential 85, leak dropped.
- Bench forces cmp_gt=cmp_lt=1 in DECIDE -> cmp_err=1 and stays 1, no spike, returns to ACCUM.
- in_valid held during REFRAC -> event accepted on the first ACCUM cycle. rst_n pulled low mid-REFRAC -> all outputs at reset values asynchronously, cmp_b=8'hFF.
- With LIF_SPIKE_COUNT_EN: 3 spikes -> spike_count=3; count_clr coincident with FIRE -> spike_count=0.
